// File: rtl/pyramid_pkg.sv
// Shared types and default geometry for the Q*bert pyramid controller.
package pyramid_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    HOP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DOWN_LEFT  = 2'd0,
    DOWN_RIGHT = 2'd1,
    UP_LEFT    = 2'd2,
    UP_RIGHT   = 2'd3
  } hop_dir_t;

  localparam logic [10:0] X_BASE   = 11'd30;
  localparam logic [9:0]  Y_BASE   = 10'd310;
  localparam logic [10:0] ROW_DX   = 11'd140;
  localparam logic [9:0]  YDIAG    = 10'd90;
  localparam int          MAX_ROWS = 7;

endpackage

// File: rtl/cube_sweep_gen.sv
// Incremental row/col walk over the pyramid producing cube index and screen offsets.
module cube_sweep_gen
  import pyramid_pkg::*;
#(
  parameter int          ROWS   = 4,
  parameter logic [10:0] X_BASE = pyramid_pkg::X_BASE,
  parameter logic [9:0]  Y_BASE = pyramid_pkg::Y_BASE,
  parameter logic [10:0] ROW_DX = pyramid_pkg::ROW_DX,
  parameter logic [9:0]  YDIAG  = pyramid_pkg::YDIAG
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_init,
  input  logic        i_advance,
  output logic [4:0]  o_idx,
  output logic [10:0] o_x,
  output logic [9:0]  o_y,
  output logic        o_last
);

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);

  logic [2:0]  r_row;
  logic [2:0]  r_col;
  logic [4:0]  r_idx;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [9:0]  r_y_rowstart;

  // Each new row starts half a cube higher than the previous row's first cube.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_init) begin
      r_row        <= '0;
      r_col        <= '0;
      r_idx        <= '0;
      r_x          <= X_BASE;
      r_y          <= Y_BASE;
      r_y_rowstart <= Y_BASE;
    end else if (i_advance) begin
      r_idx <= r_idx + 5'd1;
      if (r_col < r_row) begin
        r_col <= r_col + 3'd1;
        r_y   <= r_y + (YDIAG << 1);
      end else begin
        r_row        <= r_row + 3'd1;
        r_col        <= '0;
        r_x          <= r_x + ROW_DX;
        r_y          <= r_y_rowstart - YDIAG;
        r_y_rowstart <= r_y_rowstart - YDIAG;
      end
    end
  end

  assign o_idx  = r_idx;
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = (r_row == LAST_ROW) && (r_col == r_row);

endmodule

// File: rtl/pyramid_scheduler.sv
// Tracks Q*bert's cube, the visited bitmap and falls, and sweeps per-cube
// configuration beats to the cube_generator bank on each frame start.
module pyramid_scheduler #(
  parameter int          ROWS   = 4,
  parameter logic [10:0] X_BASE = pyramid_pkg::X_BASE,
  parameter logic [9:0]  Y_BASE = pyramid_pkg::Y_BASE,
  parameter logic [10:0] ROW_DX = pyramid_pkg::ROW_DX,
  parameter logic [9:0]  YDIAG  = pyramid_pkg::YDIAG
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic                          hop_valid,
  input  logic [1:0]                    hop_dir,
  output logic                          hop_ready,
  input  logic                          level_clear,
  output logic                          cfg_valid,
  input  logic                          cfg_ready,
  output logic [4:0]                    cfg_idx,
  output logic [10:0]                   cfg_x_offset,
  output logic [9:0]                    cfg_y_offset,
  output logic                          cfg_visited,
  output logic                          cfg_last,
  output logic [2:0]                    qbert_row,
  output logic [2:0]                    qbert_col,
  output logic [4:0]                    qbert_idx,
  output logic                          qbert_fall,
  output logic                          level_done,
  output logic [ROWS*(ROWS+1)/2-1:0]    visited
);
  import pyramid_pkg::*;

  localparam int                 N_CUBES  = ROWS * (ROWS + 1) / 2;
  localparam logic [2:0]         LAST_ROW = 3'(ROWS - 1);
  localparam logic [N_CUBES-1:0] APEX     = N_CUBES'(1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sweep_pend;
  logic               w_gen_init;
  logic               w_gen_adv;
  logic               w_gen_last;
  logic               w_hop_fire;
  logic               w_off;
  hop_dir_t           w_dir;
  logic [2:0]         r_row;
  logic [2:0]         r_col;
  logic [4:0]         r_idx;
  logic [2:0]         w_row_nxt;
  logic [2:0]         w_col_nxt;
  logic [4:0]         w_idx_nxt;
  logic [N_CUBES-1:0] r_visited;
  logic [N_CUBES-1:0] w_hop_mask;
  logic               r_fall;
  logic               r_done;

  cube_sweep_gen #(
    .ROWS   (ROWS),
    .X_BASE (X_BASE),
    .Y_BASE (Y_BASE),
    .ROW_DX (ROW_DX),
    .YDIAG  (YDIAG)
  ) u_sweep (
    .i_clk     (clk),
    .i_rst_n   (reset),
    .i_init    (w_gen_init),
    .i_advance (w_gen_adv),
    .o_idx     (cfg_idx),
    .o_x       (cfg_x_offset),
    .o_y       (cfg_y_offset),
    .o_last    (w_gen_last)
  );

  // Index moves by the row length, so no multiply is needed.
  assign w_dir = hop_dir_t'(hop_dir);
  always_comb begin
    w_off     = 1'b0;
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    w_idx_nxt = r_idx;
    case (w_dir)
      DOWN_LEFT: begin
        w_off     = (r_row >= LAST_ROW);
        w_row_nxt = r_row + 3'd1;
        w_idx_nxt = r_idx + {2'b0, r_row} + 5'd1;
      end
      DOWN_RIGHT: begin
        w_off     = (r_row >= LAST_ROW);
        w_row_nxt = r_row + 3'd1;
        w_col_nxt = r_col + 3'd1;
        w_idx_nxt = r_idx + {2'b0, r_row} + 5'd2;
      end
      UP_LEFT: begin
        w_off     = (r_row == 3'd0) || (r_col == 3'd0);
        w_row_nxt = r_row - 3'd1;
        w_col_nxt = r_col - 3'd1;
        w_idx_nxt = r_idx - {2'b0, r_row} - 5'd1;
      end
      UP_RIGHT: begin
        w_off     = (r_row == 3'd0) || (r_col == r_row);
        w_row_nxt = r_row - 3'd1;
        w_idx_nxt = r_idx - {2'b0, r_row};
      end
      default: ;
    endcase
  end

  assign w_hop_mask = APEX << w_idx_nxt;
  assign hop_ready  = reset && (r_state == IDLE) && !r_sweep_pend &&
                      !frame_start && !level_clear && !r_done;
  assign w_hop_fire = hop_valid && hop_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_gen_init  = 1'b0;
    w_gen_adv   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!level_clear) begin
          if (r_sweep_pend) begin
            w_state_nxt = SWEEP;
            w_gen_init  = 1'b1;
          end else if (w_hop_fire) begin
            w_state_nxt = HOP;
          end
        end
      end
      SWEEP: begin
        if (level_clear) begin
          w_state_nxt = IDLE;
        end else if (cfg_ready) begin
          if (w_gen_last) w_state_nxt = IDLE;
          else            w_gen_adv   = 1'b1;
        end
      end
      HOP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_sweep_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gen_init)       r_sweep_pend <= 1'b0;
      else if (frame_start) r_sweep_pend <= 1'b1;
    end
  end

  // An off-pyramid hop sends Q*bert back to the apex without marking anything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_row     <= '0;
      r_col     <= '0;
      r_idx     <= '0;
      r_visited <= APEX;
      r_fall    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      r_done <= level_clear ? 1'b0 : &r_visited;
      if (level_clear) begin
        r_row     <= '0;
        r_col     <= '0;
        r_idx     <= '0;
        r_visited <= APEX;
      end else if (w_hop_fire) begin
        if (w_off) begin
          r_row  <= '0;
          r_col  <= '0;
          r_idx  <= '0;
          r_fall <= 1'b1;
        end else begin
          r_row     <= w_row_nxt;
          r_col     <= w_col_nxt;
          r_idx     <= w_idx_nxt;
          r_visited <= r_visited | w_hop_mask;
        end
      end
    end
  end

  assign cfg_valid   = (r_state == SWEEP);
  assign cfg_last    = cfg_valid && w_gen_last;
  assign cfg_visited = cfg_valid && |(r_visited & (APEX << cfg_idx));
  assign qbert_row   = r_row;
  assign qbert_col   = r_col;
  assign qbert_idx   = r_idx;
  assign qbert_fall  = r_fall;
  assign level_done  = r_done;
  assign visited     = r_visited;

endmodule

// File: tb/tb_pyramid_scheduler.sv
// Scoreboard bench for pyramid_scheduler: directed hops, sweeps, backpressure and aborts.
module tb_pyramid_scheduler;

  logic        clk = 1'b0;
  logic        reset, frame_start, hop_valid, level_clear, cfg_ready;
  logic [1:0]  hop_dir;
  logic        hop_ready, cfg_valid, cfg_visited, cfg_last;
  logic [4:0]  cfg_idx, qbert_idx;
  logic [10:0] cfg_x_offset;
  logic [9:0]  cfg_y_offset;
  logic [2:0]  qbert_row, qbert_col;
  logic        qbert_fall, level_done;
  logic [9:0]  visited;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  logic [27:0] exp_q[$];
  logic [11:0] hop_q[$];
  int xs[10] = '{30, 170, 170, 310, 310, 310, 450, 450, 450, 450};
  int ys[10] = '{310, 220, 400, 130, 310, 490, 40, 220, 400, 580};

  logic        held;
  logic [27:0] saved;
  logic        hop_d1, hop_d2;

  always #5 clk = ~clk;

  pyramid_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .hop_valid    (hop_valid),
    .hop_dir      (hop_dir),
    .hop_ready    (hop_ready),
    .level_clear  (level_clear),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_idx      (cfg_idx),
    .cfg_x_offset (cfg_x_offset),
    .cfg_y_offset (cfg_y_offset),
    .cfg_visited  (cfg_visited),
    .cfg_last     (cfg_last),
    .qbert_row    (qbert_row),
    .qbert_col    (qbert_col),
    .qbert_idx    (qbert_idx),
    .qbert_fall   (qbert_fall),
    .level_done   (level_done),
    .visited      (visited)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] beat(input int i, input int x, input int y,
                                       input logic v, input logic l);
    return {5'(i), 11'(x), 10'(y), v, l};
  endfunction

  function automatic logic [11:0] hx(input int r, input int c, input int i, input int f);
    return {3'(r), 3'(c), 5'(i), 1'(f)};
  endfunction

  task automatic push_sweep(input logic [9:0] vis, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(beat(i, xs[i], ys[i], vis[i], i == 9));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hop(input logic [1:0] d, input logic [11:0] e);
    logic ok;
    ok = 1'b0;
    hop_q.push_back(e);
    hop_valid = 1'b1;
    hop_dir   = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hop_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hop_accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    hop_valid = 1'b0;
  endtask

  task automatic wait_sweep(input int base, input int n);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !cfg_valid) break;
      tick();
    end
    chk("sweep_drain", 32'(exp_q.size()), 32'd0);
    chk("sweep_beats", 32'(acc_cnt - base), 32'(n));
  endtask

  // Monitor: config beats against exp_q, hop results against hop_q.
  initial begin
    held = 1'b0; saved = '0; hop_d1 = 1'b0; hop_d2 = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        held = 1'b0; hop_d1 = 1'b0; hop_d2 = 1'b0;
      end else begin
        if (cfg_valid) begin
          if (held)
            chk("cfg_hold_stable",
                {4'd0, cfg_idx, cfg_x_offset, cfg_y_offset, cfg_visited, cfg_last},
                {4'd0, saved});
          if (cfg_ready) begin
            acc_cnt++;
            held = 1'b0;
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL cfg_unexpected_beat idx=%0d", cfg_idx);
            end else begin
              chk("cfg_beat",
                  {4'd0, cfg_idx, cfg_x_offset, cfg_y_offset, cfg_visited, cfg_last},
                  {4'd0, exp_q.pop_front()});
            end
          end else begin
            held  = 1'b1;
            saved = {cfg_idx, cfg_x_offset, cfg_y_offset, cfg_visited, cfg_last};
          end
        end else begin
          held = 1'b0;
        end
        if (hop_d2) chk("fall_one_cycle", 32'(qbert_fall), 32'd0);
        hop_d2 = 1'b0;
        if (hop_d1) begin
          hop_d2 = 1'b1;
          if (hop_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL hop_unexpected actual=%0d required=none", qbert_idx);
          end else begin
            chk("hop_pos", {20'd0, qbert_row, qbert_col, qbert_idx, qbert_fall},
                {20'd0, hop_q.pop_front()});
          end
        end
        hop_d1 = hop_valid && hop_ready;
        if (hop_d1 && cfg_valid) begin
          checks++; failures++;
          $display("FAIL hop_during_sweep actual=1 required=0");
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic ok;
    reset = 1'b0; frame_start = 1'b0; hop_valid = 1'b0; hop_dir = 2'd0;
    level_clear = 1'b0; cfg_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("hop_ready_in_reset", 32'(hop_ready), 32'd0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cfg_valid", 32'(cfg_valid), 32'd0);
    chk("rst_cfg_last", 32'(cfg_last), 32'd0);
    chk("rst_cfg_beat", {4'd0, cfg_idx, cfg_x_offset, cfg_y_offset, cfg_visited, cfg_last},
        {4'd0, beat(0, 30, 310, 1'b0, 1'b0)});
    chk("rst_pos", {21'd0, qbert_row, qbert_col, qbert_idx}, 32'd0);
    chk("rst_visited", 32'(visited), 32'd1);
    chk("rst_fall_done", {30'd0, qbert_fall, level_done}, 32'd0);
    chk("rst_hop_ready", 32'(hop_ready), 32'd1);

    // Reset sweep and frame_start-to-beat latency
    push_sweep(10'b0000000001, 10);
    base = acc_cnt;
    cfg_ready = 1'b1;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("sweep_lat_t1", 32'(cfg_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("sweep_lat_t2", 32'(cfg_valid), 32'd1);
    wait_sweep(base, 10);

    // Hop path
    do_hop(2'd1, hx(1, 1, 2, 0));
    do_hop(2'd0, hx(2, 1, 4, 0));
    do_hop(2'd3, hx(1, 1, 2, 0));
    @(negedge clk);
    chk("path_visited", 32'(visited), 32'b0000010101);

    // Falls
    do_hop(2'd2, hx(0, 0, 0, 0));
    do_hop(2'd2, hx(0, 0, 0, 1));
    @(negedge clk);
    chk("fall_apex_visited", 32'(visited), 32'b0000010101);
    do_hop(2'd1, hx(1, 1, 2, 0));
    do_hop(2'd1, hx(2, 2, 5, 0));
    do_hop(2'd1, hx(3, 3, 9, 0));
    do_hop(2'd1, hx(0, 0, 0, 1));
    @(negedge clk);
    chk("fall_row3_visited", 32'(visited), 32'b1000110101);

    // Level done
    do_hop(2'd0, hx(1, 0, 1, 0));
    do_hop(2'd0, hx(2, 0, 3, 0));
    do_hop(2'd0, hx(3, 0, 6, 0));
    do_hop(2'd3, hx(2, 0, 3, 0));
    do_hop(2'd1, hx(3, 1, 7, 0));
    do_hop(2'd3, hx(2, 1, 4, 0));
    do_hop(2'd1, hx(3, 2, 8, 0));
    @(negedge clk);
    chk("done_t1", 32'(level_done), 32'd0);
    tick();
    @(negedge clk);
    chk("done_t2", 32'(level_done), 32'd1);
    chk("done_visited", 32'(visited), 32'h3ff);
    chk("done_hop_ready", 32'(hop_ready), 32'd0);
    tick();
    level_clear = 1'b1;
    tick();
    level_clear = 1'b0;
    @(negedge clk);
    chk("clear_visited", 32'(visited), 32'd1);
    chk("clear_done", 32'(level_done), 32'd0);
    chk("clear_pos", {21'd0, qbert_row, qbert_col, qbert_idx}, 32'd0);
    chk("clear_hop_ready", 32'(hop_ready), 32'd1);

    // Backpressure with cfg_ready toggling
    push_sweep(10'b0000000001, 10);
    base = acc_cnt;
    tick();
    cfg_ready = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cfg_ready = ~cfg_ready;
      if (exp_q.size() == 0 && !cfg_valid) break;
    end
    chk("bp_beats", 32'(acc_cnt - base), 32'd10);
    cfg_ready = 1'b1;

    // frame_start during HOP, then hop stalled by the sweep
    do_hop(2'd0, hx(1, 0, 1, 0));
    push_sweep(10'b0000000011, 10);
    base = acc_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("hopsweep_t2", 32'(cfg_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("hopsweep_t3", 32'(cfg_valid), 32'd1);
    tick();
    hop_valid = 1'b1;
    hop_dir   = 2'd1;
    @(negedge clk);
    chk("hop_stall", 32'(hop_ready), 32'd0);
    do_hop(2'd1, hx(2, 1, 4, 0));
    wait_sweep(base, 10);
    @(negedge clk);
    chk("collide_visited", 32'(visited), 32'b0000010011);

    // Abort at beat 4 with a frame_start pending
    push_sweep(10'b0000010011, 4);
    base = acc_cnt;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      frame_start = cfg_valid && (cfg_idx == 5'd2);
      if (cfg_valid && cfg_idx == 5'd4) begin
        cfg_ready = 1'b0;
        level_clear = 1'b1;
        ok = 1'b1;
        break;
      end
    end
    chk("abort_reach_beat4", 32'(ok), 32'd1);
    tick();
    level_clear = 1'b0;
    cfg_ready = 1'b1;
    @(negedge clk);
    chk("abort_valid", 32'(cfg_valid), 32'd0);
    chk("abort_beats", 32'(acc_cnt - base), 32'd4);
    chk("abort_visited", 32'(visited), 32'd1);
    push_sweep(10'b0000000001, 10);
    base = acc_cnt;
    wait_sweep(base, 10);

    // Reset in the middle of a sweep
    push_sweep(10'b0000000001, 3);
    base = acc_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cfg_valid && cfg_idx == 5'd3) begin
        cfg_ready = 1'b0;
        reset = 1'b0;
        break;
      end
    end
    tick();
    reset = 1'b1;
    cfg_ready = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 32'(cfg_valid), 32'd0);
    chk("rstmid_last", 32'(cfg_last), 32'd0);
    chk("rstmid_beats", 32'(acc_cnt - base), 32'd3);
    repeat (4) tick();
    @(negedge clk);
    chk("rstmid_no_resume", 32'(cfg_valid), 32'd0);
    chk("rstmid_queue", 32'(exp_q.size() + hop_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
